memory_access_stage: RTL and testbench

Pipeline MEM stage, directly downstream of the execute stage. Consumes the EX/MEM payload (ALU result, store data, destination register, control bits) and performs load/store through a req/ack data-memory port. Stalls upstream while an access is outstanding. Registers the MEM/WB payload for write-back and exposes the ALU result combinationally for EX forwarding.

---
 rtl/memory_access_stage_pkg.sv | 14 +
 rtl/memory_access_stage_access_watchdog.sv | 35 +++
 rtl/memory_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: datapath widths, the
// FSM state encoding and the default access-timeout limit.
package memory_access_stage_pkg;

  localparam int unsigned MAS_DATA_W          = 32;
  localparam int unsigned MAS_REG_W           = 5;
  localparam int unsigned MAS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/memory_access_stage_access_watchdog.sv
// Access watchdog for the MEM stage: an 8-bit cycle counter that runs while
// a data-memory access is outstanding and flags expiry in the cycle that
// would be the TIMEOUT_CYCLES-th request cycle. Only instantiated when
// MEM_TIMEOUT_EN is defined.
module access_watchdog
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MAS_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_run,
  output logic o_expire
);

  // Count value held during the last allowed request cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;

  // Clear on access entry, then count every ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage. Passes non-memory ops straight into MEM/WB, and runs
// loads/stores through a req/ack data-memory port while stalling upstream.
// The ALU result is echoed combinationally for EX forwarding.
// Optional feature: define MEM_TIMEOUT_EN to add the access watchdog that
// aborts a hung access after TIMEOUT_CYCLES request cycles and raises the
// sticky errorOutput flag; without it errorOutput is tied low.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MAS_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validInput,
  input  logic        memToRegInput,
  input  logic        regWriteInput,
  input  logic        memWriteInput,
  input  logic        memReadInput,
  input  logic [31:0] aluResultInput,
  input  logic [31:0] memWriteDataInput,
  input  logic [4:0]  regWriteRegisterInput,
  output logic [31:0] aluResultMemOutput,
  output logic        stallOutput,
  output logic        memReqOutput,
  output logic        memWeOutput,
  output logic [31:0] memAddrOutput,
  output logic [31:0] memWdataOutput,
  input  logic        memAckInput,
  input  logic [31:0] memRdataInput,
  output logic        validOutput,
  output logic        memToRegOutput,
  output logic        regWriteOutput,
  output logic [31:0] readDataOutput,
  output logic [31:0] aluResultOutput,
  output logic [4:0]  regWriteRegisterOutput,
  output logic        errorOutput
);

  localparam int unsigned DATA_W = MAS_DATA_W;
  localparam int unsigned REG_W  = MAS_REG_W;

  // The watchdog counter is 8 bits wide, so the limit must fit in 1..255.
  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 1..255");
    end
  endgenerate

  state_e              r_state;
  logic                r_req;
  logic                r_we;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_lat_m2r;
  logic                r_lat_rw;
  logic [REG_W-1:0]    r_lat_rd;

  logic                r_wb_valid;
  logic                r_wb_m2r;
  logic                r_wb_rw;
  logic [DATA_W-1:0]   r_wb_rdata;
  logic [DATA_W-1:0]   r_wb_alu;
  logic [REG_W-1:0]    r_wb_rd;

  logic                w_in_access;
  logic                w_is_memop;
  logic                w_capture;
  logic                w_ack_done;
  logic                w_expire;
  logic                w_timeout;

  assign w_in_access = (r_state == ST_ACCESS);
  assign w_is_memop  = memReadInput || memWriteInput;
  assign w_capture   = !w_in_access && validInput && w_is_memop;
  assign w_ack_done  = w_in_access && memAckInput;
  // A real ack in the final allowed cycle wins over the watchdog.
  assign w_timeout   = w_in_access && w_expire && !memAckInput;

`ifdef MEM_TIMEOUT_EN
  logic r_err;

  access_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_access_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_capture),
    .i_run    (w_in_access),
    .o_expire (w_expire)
  );

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign errorOutput = r_err;
`else
  assign w_expire    = 1'b0;
  assign errorOutput = 1'b0;
`endif

  // ---- capture / request stage: FSM plus registered memory port ----
  // Latch the op on entry to ACCESS and hold the request until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lat_m2r <= 1'b0;
      r_lat_rw  <= 1'b0;
      r_lat_rd  <= '0;
    end else if (w_capture) begin
      r_state   <= ST_ACCESS;
      r_req     <= 1'b1;
      r_we      <= memWriteInput;
      r_addr    <= aluResultInput;
      r_wdata   <= memWriteDataInput;
      r_lat_m2r <= memToRegInput;
      r_lat_rw  <= regWriteInput;
      r_lat_rd  <= regWriteRegisterInput;
    end else if (w_ack_done || w_timeout) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
    end
  end

  // ---- MEM/WB stage ----
  // Write-back register: direct for ALU ops, from the latch on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_wb_m2r   <= 1'b0;
      r_wb_rw    <= 1'b0;
      r_wb_rdata <= '0;
      r_wb_alu   <= '0;
      r_wb_rd    <= '0;
    end else if (!w_in_access) begin
      if (validInput && !w_is_memop) begin
        r_wb_valid <= 1'b1;
        r_wb_m2r   <= memToRegInput;
        r_wb_rw    <= regWriteInput;
        r_wb_rdata <= '0;
        r_wb_alu   <= aluResultInput;
        r_wb_rd    <= regWriteRegisterInput;
      end else begin
        // Empty slot or an op entering ACCESS: bubble, fields hold.
        r_wb_valid <= 1'b0;
      end
    end else if (w_ack_done) begin
      r_wb_valid <= 1'b1;
      r_wb_m2r   <= r_lat_m2r;
      r_wb_rw    <= r_lat_rw;
      r_wb_rdata <= r_we ? '0 : memRdataInput;
      r_wb_alu   <= r_addr;
      r_wb_rd    <= r_lat_rd;
    end else if (w_timeout) begin
      // Abandoned access retires without touching the register file.
      r_wb_valid <= 1'b1;
      r_wb_m2r   <= r_lat_m2r;
      r_wb_rw    <= 1'b0;
      r_wb_rdata <= '0;
      r_wb_alu   <= r_addr;
      r_wb_rd    <= r_lat_rd;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  assign aluResultMemOutput     = aluResultInput;
  assign stallOutput            = w_in_access;
  assign memReqOutput           = r_req;
  assign memWeOutput            = r_we;
  assign memAddrOutput          = r_addr;
  assign memWdataOutput         = r_wdata;
  assign validOutput            = r_wb_valid;
  assign memToRegOutput         = r_wb_m2r;
  assign regWriteOutput         = r_wb_rw;
  assign readDataOutput         = r_wb_rdata;
  assign aluResultOutput        = r_wb_alu;
  assign regWriteRegisterOutput = r_wb_rd;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus a
// randomized instruction stream, checked against a transaction-level model
// of the MEM/WB contents and the request/stall timing.
module tb_memory_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO    = 4;
  localparam bit          WD_EN = 1'b1;
`else
  localparam int unsigned TO    = 255;
  localparam bit          WD_EN = 1'b0;
`endif

  logic        reset;
  logic        validInput, memToRegInput, regWriteInput, memWriteInput, memReadInput;
  logic [31:0] aluResultInput, memWriteDataInput;
  logic [4:0]  regWriteRegisterInput;
  logic [31:0] aluResultMemOutput;
  logic        stallOutput, memReqOutput, memWeOutput;
  logic [31:0] memAddrOutput, memWdataOutput;
  logic        memAckInput;
  logic [31:0] memRdataInput;
  logic        validOutput, memToRegOutput, regWriteOutput;
  logic [31:0] readDataOutput, aluResultOutput;
  logic [4:0]  regWriteRegisterOutput;
  logic        errorOutput;

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .validInput(validInput), .memToRegInput(memToRegInput),
    .regWriteInput(regWriteInput), .memWriteInput(memWriteInput),
    .memReadInput(memReadInput), .aluResultInput(aluResultInput),
    .memWriteDataInput(memWriteDataInput),
    .regWriteRegisterInput(regWriteRegisterInput),
    .aluResultMemOutput(aluResultMemOutput), .stallOutput(stallOutput),
    .memReqOutput(memReqOutput), .memWeOutput(memWeOutput),
    .memAddrOutput(memAddrOutput), .memWdataOutput(memWdataOutput),
    .memAckInput(memAckInput), .memRdataInput(memRdataInput),
    .validOutput(validOutput), .memToRegOutput(memToRegOutput),
    .regWriteOutput(regWriteOutput), .readDataOutput(readDataOutput),
    .aluResultOutput(aluResultOutput),
    .regWriteRegisterOutput(regWriteRegisterOutput),
    .errorOutput(errorOutput)
  );

  typedef struct {
    bit          v, rd_en, wr_en, m2r, rw;
    logic [31:0] alu, wd, rdata;
    logic [4:0]  rd;
    int          k;
  } instr_t;

  // Expected MEM/WB register contents and sticky error flag.
  logic        e_valid, e_m2r, e_rw, e_err;
  logic [31:0] e_alu, e_rdata;
  logic [4:0]  e_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_wb();
    chk("wb_valid", validOutput, e_valid);
    chk("wb_m2r", memToRegOutput, e_m2r);
    chk("wb_rw", regWriteOutput, e_rw);
    chk("wb_rdata", readDataOutput, e_rdata);
    chk("wb_alu", aluResultOutput, e_alu);
    chk("wb_rd", regWriteRegisterOutput, e_rd);
    chk("error", errorOutput, e_err);
  endtask

  function automatic instr_t mk(bit v, bit rd_en, bit wr_en, bit m2r, bit rw,
                                logic [31:0] alu, logic [31:0] wd,
                                logic [31:0] rdata, logic [4:0] rd, int k);
    instr_t t;
    t.v = v; t.rd_en = rd_en; t.wr_en = wr_en; t.m2r = m2r; t.rw = rw;
    t.alu = alu; t.wd = wd; t.rdata = rdata; t.rd = rd; t.k = k;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    int r;
    r = $urandom_range(0, 9);
    return mk(r != 0, (r >= 5 && r <= 6) || r == 9, r >= 7,
              1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
              5'($urandom), $urandom_range(1, 4));
  endfunction

  task automatic apply(input instr_t t);
    validInput            = t.v;
    memReadInput          = t.rd_en;
    memWriteInput         = t.wr_en;
    memToRegInput         = t.m2r;
    regWriteInput         = t.rw;
    aluResultInput        = t.alu;
    memWriteDataInput     = t.wd;
    regWriteRegisterInput = t.rd;
  endtask

  task automatic junk();
    apply(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1));
  endtask

  // Present one instruction in IDLE, play memory for it, and check the
  // request phase and the resulting MEM/WB contents. While stalled, the
  // following instruction (or noise) sits on the inputs.
  task automatic run_instr(input instr_t t, input instr_t nxt, input bit has_nxt);
    bit done, timed_out;
    int nstall;
    apply(t);
    memAckInput   = 1'($urandom);   // ack in IDLE must be ignored
    memRdataInput = $urandom;
    #1;
    chk("fwd_alu", aluResultMemOutput, t.alu);
    chk("stall_idle", stallOutput, 1'b0);
    @(negedge clk);
    memAckInput = 1'b0;
    if (!(t.v && (t.rd_en || t.wr_en))) begin
      e_valid = t.v;
      if (t.v) begin
        e_m2r = t.m2r; e_rw = t.rw; e_rd = t.rd; e_alu = t.alu; e_rdata = '0;
      end
      check_wb();
      chk("req_idle", memReqOutput, 1'b0);
      chk("stall_after_alu", stallOutput, 1'b0);
    end else begin
      done = 1'b0; timed_out = 1'b0; nstall = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
        chk("acc_valid", validOutput, 1'b0);
        chk("acc_req", memReqOutput, 1'b1);
        chk("acc_addr", memAddrOutput, t.alu);
        chk("acc_we", memWeOutput, t.wr_en);
        chk("acc_wdata", memWdataOutput, t.wd);
        chk("acc_stall", stallOutput, 1'b1);
        nstall++;
        if (has_nxt && $urandom_range(0, 3) != 0) apply(nxt);
        else junk();
        memAckInput   = (c == t.k);
        memRdataInput = (c == t.k) ? t.rdata : $urandom;
        @(negedge clk);
        memAckInput = 1'b0;
        if (c == t.k) done = 1'b1;
        else if (WD_EN && c == int'(TO)) begin
          done = 1'b1; timed_out = 1'b1;
        end
      end
      chk("access_done", done, 1'b1);
      chk("stall_cycles", nstall, timed_out ? int'(TO) : t.k);
      e_valid = 1'b1; e_m2r = t.m2r; e_rd = t.rd; e_alu = t.alu;
      e_rw    = timed_out ? 1'b0 : t.rw;
      e_rdata = (timed_out || t.wr_en) ? 32'h0 : t.rdata;
      if (timed_out) e_err = 1'b1;
      check_wb();
      chk("req_done", memReqOutput, 1'b0);
      chk("stall_done", stallOutput, 1'b0);
    end
  endtask

  function automatic instr_t bubble();
    return mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 1);
  endfunction

  instr_t lst[150];

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    apply(bubble());
    memAckInput = 1'b0; memRdataInput = '0;
    e_valid = 0; e_m2r = 0; e_rw = 0; e_err = 0; e_alu = '0; e_rdata = '0; e_rd = '0;
    @(negedge clk); @(negedge clk);
    check_wb();
    chk("rst_req", memReqOutput, 1'b0);
    chk("rst_we", memWeOutput, 1'b0);
    chk("rst_addr", memAddrOutput, 32'h0);
    chk("rst_wdata", memWdataOutput, 32'h0);
    chk("rst_stall", stallOutput, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Reset while a load is outstanding, then a late ack.
    apply(mk(1, 1, 0, 1, 1, 32'h100, 32'h0, 32'h0, 5'd3, 3));
    @(negedge clk);
    chk("rst_pre_req", memReqOutput, 1'b1);
    chk("rst_pre_stall", stallOutput, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid_req", memReqOutput, 1'b0);
    chk("rst_mid_stall", stallOutput, 1'b0);
    chk("rst_mid_valid", validOutput, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    apply(bubble());
    memAckInput = 1'b1; memRdataInput = 32'hBAD0BAD0;
    @(negedge clk);
    memAckInput = 1'b0;
    chk("late_ack_req", memReqOutput, 1'b0);
    chk("late_ack_stall", stallOutput, 1'b0);
    check_wb();

    // Directed scenarios.
    run_instr(mk(1, 0, 0, 0, 1, 32'h10, 32'h0, 32'h0, 5'd5, 1), bubble(), 1'b0);
    run_instr(mk(1, 1, 0, 1, 1, 32'h40, 32'h0, 32'hCAFEF00D, 5'd9, 3), bubble(), 1'b0);
    run_instr(mk(1, 0, 1, 0, 0, 32'h80, 32'h12345678, 32'h5555AAAA, 5'd0, 1), bubble(), 1'b0);
    run_instr(mk(1, 1, 0, 1, 1, 32'h44, 32'h0, 32'h0BADBEEF, 5'd2, 2),
              mk(1, 0, 0, 0, 1, 32'h77, 32'h0, 32'h0, 5'd11, 1), 1'b1);
    run_instr(mk(1, 0, 0, 0, 1, 32'h77, 32'h0, 32'h0, 5'd11, 1), bubble(), 1'b0);
    run_instr(mk(1, 1, 1, 1, 1, 32'h90, 32'hFEEDFACE, 32'h11112222, 5'd7, 2), bubble(), 1'b0);
    run_instr(bubble(), bubble(), 1'b0);

    // Randomized stream.
    foreach (lst[i]) lst[i] = rand_instr();
    for (int i = 0; i < 150; i++) begin
      if (i < 149) run_instr(lst[i], lst[i+1], 1'b1);
      else         run_instr(lst[i], bubble(), 1'b0);
    end

`ifdef MEM_TIMEOUT_EN
    // Hung load: watchdog aborts it; error stays set afterwards.
    run_instr(mk(1, 1, 0, 1, 1, 32'hA0, 32'h0, 32'hDEADDEAD, 5'd12, 1000), bubble(), 1'b0);
    run_instr(mk(1, 0, 0, 1, 1, 32'h33, 32'h0, 32'h0, 5'd4, 1), bubble(), 1'b0);
    run_instr(mk(1, 0, 1, 0, 0, 32'hB0, 32'h1, 32'h0, 5'd1, 2), bubble(), 1'b0);
`endif
    run_instr(bubble(), bubble(), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
